// File: rtl/ofmap_axis_packer.sv
// rtl/ofmap_axis_packer.sv - packs conv elements / pool bits / bypass words into an AXI-Stream master through a word FIFO
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   operation             0 conv pack, 1 pool bit pack, 2 word bypass, 3 discard (latched on the first beat of a layer)
//   in_valid/in_ready     input beat handshake; in_data (element or bit 0), in_word (bypass), in_last (end of layer)
//   M_AXIS_*              AXI-Stream master (TVALID/TDATA/TKEEP/TLAST/TREADY)
//   fifo_cnt              words currently queued
//   word_count            output handshakes in the current layer (saturating)
//   busy                  layer in progress
module ofmap_axis_packer #(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int ELEM_WIDTH           = 8,
  parameter int FIFO_DEPTH           = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [1:0]                          operation,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [ELEM_WIDTH-1:0]               in_data,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0]     in_word,
  input  logic                                in_last,
  output logic                                M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TKEEP,
  output logic                                M_AXIS_TLAST,
  input  logic                                M_AXIS_TREADY,
  output logic [$clog2(FIFO_DEPTH):0]         fifo_cnt,
  output logic [15:0]                         word_count,
  output logic                                busy
);

  localparam int W   = C_M_AXIS_TDATA_WIDTH;
  localparam int KW  = W / 8;
  localparam int EPW = W / ELEM_WIDTH;
  localparam int CW  = $clog2(FIFO_DEPTH);
  localparam int LW  = $clog2(W);
  localparam int FW  = W + KW + 1;

  localparam logic [1:0] OP_CONV    = 2'd0;
  localparam logic [1:0] OP_POOL    = 2'd1;
  localparam logic [1:0] OP_BYPASS  = 2'd2;
  localparam logic [1:0] OP_DISCARD = 2'd3;

  typedef enum logic [1:0] {IDLE, PACK, DRAIN} state_t;

  state_t          state, state_nx;
  logic [1:0]      op_q, op_eff;
  logic [LW-1:0]   lane;
  logic [W-1:0]    pack, pack_nx;
  logic            accept, last_lane, packing, push, pop, tlast_pop, clr_wc;
  logic [W-1:0]    push_data;
  logic [KW-1:0]   push_keep;
  int              nbits;

  logic [FW-1:0]   mem [FIFO_DEPTH];
  logic [FW-1:0]   head;
  logic [CW-1:0]   wr_ptr, rd_ptr;
  logic [CW:0]     count;

  // The operation is only sampled in IDLE; mid-layer changes are ignored.
  assign op_eff   = (state == IDLE) ? operation : op_q;
  assign in_ready = rst_n && (state != DRAIN) && (count < (CW+1)'(FIFO_DEPTH));
  assign accept   = in_valid && in_ready;
  assign packing  = (op_eff == OP_CONV) || (op_eff == OP_POOL);

  always_comb begin
    pack_nx   = pack;
    last_lane = 1'b0;
    nbits     = 0;
    push      = 1'b0;
    push_data = in_word;
    push_keep = '1;
    case (op_eff)
      OP_CONV: begin
        pack_nx   = pack | (W'(in_data) << (int'(lane) * ELEM_WIDTH));
        last_lane = (int'(lane) == EPW - 1);
        nbits     = (int'(lane) + 1) * ELEM_WIDTH;
      end
      OP_POOL: begin
        pack_nx   = pack | (W'(in_data[0]) << lane);
        last_lane = (int'(lane) == W - 1);
        nbits     = int'(lane) + 1;
      end
      default: ;
    endcase
    if (packing) begin
      push      = accept && (last_lane || in_last);
      push_data = pack_nx;
      // A byte is kept when it holds at least one valid element or bit.
      for (int b = 0; b < KW; b++) push_keep[b] = (b * 8 < nbits);
    end else if (op_eff == OP_BYPASS) begin
      push = accept;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane <= '0;
      pack <= '0;
      op_q <= OP_CONV;
    end else if (accept) begin
      if (state == IDLE) op_q <= operation;
      if (packing && !(last_lane || in_last)) begin
        lane <= lane + 1'b1;
        pack <= pack_nx;
      end else begin
        lane <= '0;
        pack <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = (state != IDLE);
    case (state)
      IDLE:    if (accept) state_nx = in_last ? ((op_eff == OP_DISCARD) ? IDLE : DRAIN) : PACK;
      PACK:    if (accept && in_last) state_nx = (op_eff == OP_DISCARD) ? IDLE : DRAIN;
      DRAIN:   if (tlast_pop) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Word FIFO; pointers wrap naturally because FIFO_DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {push_data, push_keep, in_last};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head          = mem[rd_ptr];
  assign M_AXIS_TVALID = (count != '0);
  assign M_AXIS_TDATA  = M_AXIS_TVALID ? head[FW-1:KW+1] : '0;
  assign M_AXIS_TKEEP  = M_AXIS_TVALID ? head[KW:1]      : '0;
  assign M_AXIS_TLAST  = M_AXIS_TVALID ? head[0]         : 1'b0;
  assign pop           = M_AXIS_TVALID && M_AXIS_TREADY;
  assign tlast_pop     = pop && M_AXIS_TLAST;
  assign fifo_cnt      = count;

  // The clear lands one cycle after DRAIN->IDLE so the layer's final count is visible for a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_count <= '0;
      clr_wc     <= 1'b0;
    end else begin
      clr_wc <= (state == DRAIN) && tlast_pop;
      if (clr_wc)                           word_count <= '0;
      else if (pop && word_count != 16'hFFFF) word_count <= word_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_ofmap_axis_packer.sv
// tb/tb_ofmap_axis_packer.sv - scoreboard bench for ofmap_axis_packer
module tb_ofmap_axis_packer;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, in_ready, in_last;
  logic [1:0]  operation;
  logic [7:0]  in_data;
  logic [31:0] in_word;
  logic        tvalid, tlast, tready, busy;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic [2:0]  fifo_cnt;
  logic [15:0] word_count;

  ofmap_axis_packer #(.C_M_AXIS_TDATA_WIDTH(32), .ELEM_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .operation(operation), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_word(in_word), .in_last(in_last),
    .M_AXIS_TVALID(tvalid), .M_AXIS_TDATA(tdata), .M_AXIS_TKEEP(tkeep), .M_AXIS_TLAST(tlast),
    .M_AXIS_TREADY(tready), .fifo_cnt(fifo_cnt), .word_count(word_count), .busy(busy)
  );

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [36:0] exp_q[$];
  logic [36:0] obs_q[$];
  logic [7:0]  m_elems[$];
  bit          m_active = 0;
  logic [1:0]  m_op;
  bit          rand_rdy = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Reference model: gather the elements of the current word, build it arithmetically when it closes.
  task automatic emit(input int ew, input bit last);
    logic [31:0] d;
    int nb;
    d = 0;
    foreach (m_elems[i]) d |= 32'(m_elems[i]) << (i * ew);
    nb = (m_elems.size() * ew + 7) / 8;
    exp_q.push_back({d, 4'((1 << nb) - 1), last});
    m_elems.delete();
  endtask

  task automatic model_accept(input logic [1:0] op, input logic [7:0] d, input logic [31:0] w, input bit last);
    if (!m_active) begin
      m_op = op;
      m_active = 1;
    end
    case (m_op)
      2'd0: begin m_elems.push_back(d);          if (m_elems.size() == 4 || last)  emit(8, last); end
      2'd1: begin m_elems.push_back(8'(d[0]));   if (m_elems.size() == 32 || last) emit(1, last); end
      2'd2: exp_q.push_back({w, 4'hF, last});
      default: ;
    endcase
    if (last) m_active = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] d, input logic [31:0] w, input bit last);
    int n;
    n = 0;
    operation = op; in_data = d; in_word = w; in_last = last; in_valid = 1;
    while (!in_ready && n < 400) begin step(); n++; end
    if (!in_ready) begin
      in_valid = 0;
      n_cmp++; n_fail++;
      $display("FAIL send_timeout: in_ready=0 expected 1");
      return;
    end
    model_accept(op, d, w, last);
    step();
    in_valid = 0; in_last = 0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((busy || tvalid) && n < 2000) begin step(); n++; end
    chk(nm, {busy, tvalid}, 2'b00);
  endtask

  task automatic chk_obs(input string nm, input int idx, input logic [36:0] e);
    if (idx < obs_q.size()) chk(nm, obs_q[idx], e);
    else begin n_cmp++; n_fail++; $display("FAIL %s: got no beat expected %h", nm, e); end
  endtask

  // Monitor: compare every output handshake against the scoreboard and check stability under backpressure.
  logic        hold = 0;
  logic [36:0] held;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) hold = 0;
      else begin
        if (hold) chk("hold_stable", {tvalid, tdata, tkeep, tlast}, {1'b1, held});
        if (tvalid && tready) begin
          obs_q.push_back({tdata, tkeep, tlast});
          if (exp_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL beat: got %h expected none", {tdata, tkeep, tlast});
          end else chk("beat", {tdata, tkeep, tlast}, exp_q.pop_front());
        end
        hold = tvalid && !tready;
        held = {tdata, tkeep, tlast};
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) tready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [1:0] lop;
    int len;
    rst_n = 0; in_valid = 0; in_last = 0; operation = 0; in_data = 0; in_word = 0; tready = 0;
    repeat (3) step();
    chk("rst_tvalid", tvalid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_fifo_cnt", fifo_cnt, 0);
    chk("rst_word_count", word_count, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1; tready = 1;
    step();

    // Full conv word
    obs_q.delete();
    send(0, 8'h11, 0, 0); send(0, 8'h22, 0, 0); send(0, 8'h33, 0, 0); send(0, 8'h44, 0, 1);
    chk("conv_latency_tvalid", tvalid, 1);
    wait_idle("conv_idle");
    chk("conv_nbeats", obs_q.size(), 1);
    chk_obs("conv_beat", 0, {32'h44332211, 4'hF, 1'b1});

    // Partial conv word and word_count
    obs_q.delete();
    for (int i = 1; i <= 6; i++) send(0, 8'(i), 0, i == 6);
    n = 0;
    while (busy && n < 100) begin step(); n++; end
    chk("wc_before_clear", word_count, 2);
    step();
    chk("wc_cleared", word_count, 0);
    chk("partial_nbeats", obs_q.size(), 2);
    chk_obs("partial_beat0", 0, {32'h04030201, 4'hF, 1'b0});
    chk_obs("partial_beat1", 1, {32'h00000605, 4'h3, 1'b1});

    // Backpressure
    obs_q.delete();
    tready = 0;
    fork
      begin
        for (int i = 1; i <= 20; i++) send(0, 8'(i), 0, i == 20);
      end
      begin
        n = 0;
        while (fifo_cnt != 3'd4 && n < 200) begin step(); n++; end
        chk("bp_fifo_full", fifo_cnt, 4);
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_head", tdata, 32'h04030201);
        repeat (5) step();
        chk("bp_head_held", {tvalid, tdata}, {1'b1, 32'h04030201});
        tready = 1;
      end
    join
    wait_idle("bp_idle");
    chk("bp_nbeats", obs_q.size(), 5);
    for (int k = 0; k < 5; k++)
      chk_obs("bp_beat", k, {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 4'hF, k == 4});

    // Pool bits
    obs_q.delete();
    for (int i = 0; i < 40; i++) send(1, (i % 2 == 0) ? 8'h01 : 8'h00, 0, i == 39);
    wait_idle("pool_idle");
    chk("pool_nbeats", obs_q.size(), 2);
    chk_obs("pool_beat0", 0, {32'h55555555, 4'hF, 1'b0});
    chk_obs("pool_beat1", 1, {32'h00000055, 4'h1, 1'b1});

    // Bypass with operation change mid-layer
    obs_q.delete();
    send(2, 0, 32'hDEADBEEF, 0);
    send(0, 0, 32'hCAFEF00D, 1);
    wait_idle("bypass_idle");
    chk("bypass_nbeats", obs_q.size(), 2);
    chk_obs("bypass_beat0", 0, {32'hDEADBEEF, 4'hF, 1'b0});
    chk_obs("bypass_beat1", 1, {32'hCAFEF00D, 4'hF, 1'b1});

    // Discard returns straight to IDLE
    obs_q.delete();
    send(3, 8'h77, 0, 0); send(3, 8'h78, 0, 1);
    chk("discard_idle", {busy, tvalid}, 2'b00);
    repeat (3) step();
    chk("discard_nbeats", obs_q.size(), 0);

    // Reset mid-layer
    send(0, 8'h5A, 0, 0); send(0, 8'h5B, 0, 0); send(0, 8'h5C, 0, 0);
    rst_n = 0;
    #1;
    chk("midrst_tvalid", tvalid, 0);
    chk("midrst_fifo_cnt", fifo_cnt, 0);
    chk("midrst_in_ready", in_ready, 0);
    m_elems.delete(); m_active = 0; exp_q.delete(); obs_q.delete();
    step(); step();
    rst_n = 1;
    repeat (5) step();
    chk("postrst_tvalid", tvalid, 0);
    send(0, 8'hA1, 0, 0); send(0, 8'hA2, 0, 0); send(0, 8'hA3, 0, 0); send(0, 8'hA4, 0, 1);
    wait_idle("postrst_idle");
    chk("postrst_nbeats", obs_q.size(), 1);
    chk_obs("postrst_beat", 0, {32'hA4A3A2A1, 4'hF, 1'b1});

    // Randomized layers against the model
    rand_rdy = 1;
    for (int l = 0; l < 40; l++) begin
      lop = 2'($urandom_range(0, 3));
      len = $urandom_range(1, 40);
      for (int b = 0; b < len; b++) begin
        repeat ($urandom_range(0, 2)) step();
        send((b == 0) ? lop : 2'($urandom_range(0, 3)), 8'($urandom), $urandom, b == len - 1);
      end
    end
    rand_rdy = 0;
    step();
    tready = 1;
    wait_idle("rand_idle");
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
